// File: rtl/stream_adder_top.sv
// Join-and-add of two valid/ready streams through per-channel skid FIFOs.
// Ports: ref_clk/rst (sync, active-high), clk_out (forwarded ref_clk),
//   dinp_a/valid_a/ready_a, dinp_b/valid_b/ready_b (input streams),
//   out/valid_out (registered DATA_W+1 sum, consumer always accepts).

module stream_adder_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         push,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         ready,
  output logic         nonempty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign head     = mem[rd_ptr];
  // Full deasserts ready even when popping this cycle.
  assign ready    = !rst && (count < FULL);
  assign nonempty = (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module stream_adder_top #(
  parameter int DATA_W     = 8,
  parameter int SKID_DEPTH = 2
) (
  input  logic              ref_clk,
  input  logic              rst,
  output logic              clk_out,
  input  logic [DATA_W-1:0] dinp_a,
  input  logic              valid_a,
  output logic              ready_a,
  input  logic [DATA_W-1:0] dinp_b,
  input  logic              valid_b,
  output logic              ready_b,
  output logic [DATA_W:0]   out,
  output logic              valid_out
);
  logic              push_a;
  logic              push_b;
  logic              ne_a;
  logic              ne_b;
  logic              pop;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;

  assign clk_out = ref_clk;
  assign push_a  = valid_a && ready_a;
  assign push_b  = valid_b && ready_b;
  // Operands are only ever consumed as a pair.
  assign pop     = ne_a && ne_b;

  stream_adder_fifo #(
    .W     (DATA_W),
    .DEPTH (SKID_DEPTH)
  ) u_fifo_a (
    .clk      (ref_clk),
    .rst      (rst),
    .din      (dinp_a),
    .push     (push_a),
    .pop      (pop),
    .head     (head_a),
    .ready    (ready_a),
    .nonempty (ne_a)
  );

  stream_adder_fifo #(
    .W     (DATA_W),
    .DEPTH (SKID_DEPTH)
  ) u_fifo_b (
    .clk      (ref_clk),
    .rst      (rst),
    .din      (dinp_b),
    .push     (push_b),
    .pop      (pop),
    .head     (head_b),
    .ready    (ready_b),
    .nonempty (ne_b)
  );

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      out       <= '0;
      valid_out <= 1'b0;
    end else if (pop) begin
      out       <= {1'b0, head_a} + {1'b0, head_b};
      valid_out <= 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_adder_top.sv
// Directed/randomized bench for stream_adder_top against a queue model.
// Model: two FIFO queues, paired pops, registered sum one edge later.

module tb_stream_adder_top;
  localparam int DW = 8;
  localparam int DEPTH = 2;

  logic          ref_clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_out;
  logic [DW-1:0] dinp_a = '0;
  logic          valid_a = 1'b0;
  logic          ready_a;
  logic [DW-1:0] dinp_b = '0;
  logic          valid_b = 1'b0;
  logic          ready_b;
  logic [DW:0]   out;
  logic          valid_out;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] src_a[$];
  logic [DW-1:0] src_b[$];
  logic [DW-1:0] mq_a[$];
  logic [DW-1:0] mq_b[$];
  logic [DW:0]   exp_out = '0;
  logic          exp_valid = 1'b0;

  stream_adder_top #(
    .DATA_W     (DW),
    .SKID_DEPTH (DEPTH)
  ) dut (
    .ref_clk   (ref_clk),
    .rst       (rst),
    .clk_out   (clk_out),
    .dinp_a    (dinp_a),
    .valid_a   (valid_a),
    .ready_a   (ready_a),
    .dinp_b    (dinp_b),
    .valid_b   (valid_b),
    .ready_b   (ready_b),
    .out       (out),
    .valid_out (valid_out)
  );

  always #5 ref_clk = ~ref_clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [DW:0] got,
                     input logic [DW:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // mode: 0 off, 1 always, 2 toggle, 3 random
  function automatic bit en(input int mode, input int k);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (k % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic cycle(input bit r, input int ma, input int mb,
                       input int k);
    bit ra;
    bit rb;
    bit acc_a;
    bit acc_b;
    rst = r;
    valid_a = (src_a.size() > 0) && en(ma, k);
    valid_b = (src_b.size() > 0) && en(mb, k);
    dinp_a = valid_a ? src_a[0] : DW'($urandom);
    dinp_b = valid_b ? src_b[0] : DW'($urandom);
    #3;
    ra = !r && (mq_a.size() < DEPTH);
    rb = !r && (mq_b.size() < DEPTH);
    chk("ready_a", {8'd0, ready_a}, {8'd0, ra});
    chk("ready_b", {8'd0, ready_b}, {8'd0, rb});
    chk("clk_out", {8'd0, clk_out}, {8'd0, ref_clk});
    acc_a = valid_a && ra;
    acc_b = valid_b && rb;
    @(posedge ref_clk);
    if (r) begin
      mq_a.delete();
      mq_b.delete();
      exp_out = '0;
      exp_valid = 1'b0;
    end else begin
      if (mq_a.size() > 0 && mq_b.size() > 0) begin
        exp_out = {1'b0, mq_a.pop_front()} + {1'b0, mq_b.pop_front()};
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      if (acc_a) mq_a.push_back(src_a.pop_front());
      if (acc_b) mq_b.push_back(src_b.pop_front());
    end
    #1;
    chk("valid_out", {8'd0, valid_out}, {8'd0, exp_valid});
    chk("out", out, exp_out);
  endtask

  task automatic run(input int n, input int ma, input int mb);
    for (int k = 0; k < n; k++) cycle(1'b0, ma, mb, k);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 0, 0, k);
  endtask

  task automatic clear_src;
    src_a.delete();
    src_b.delete();
  endtask

  initial begin
    @(posedge ref_clk);
    #1;
    do_reset(3);

    // continuous counting streams: 3,5,7,...
    for (int i = 0; i < 30; i++) begin
      src_a.push_back(DW'(i + 1));
      src_b.push_back(DW'(i + 2));
    end
    run(34, 1, 1);

    // carry
    clear_src();
    do_reset(1);
    src_a.push_back(8'd255); src_b.push_back(8'd255);
    src_a.push_back(8'd255); src_b.push_back(8'd1);
    run(5, 1, 1);
    chk("carry_last", out, 9'h100);

    // skew: B idle while A offers 10,11,12
    clear_src();
    do_reset(1);
    src_a.push_back(8'd10); src_a.push_back(8'd11); src_a.push_back(8'd12);
    run(5, 1, 0);
    chk("skew_ready_a_low", {8'd0, ready_a}, 9'd0);
    src_b.push_back(8'd1); src_b.push_back(8'd2); src_b.push_back(8'd3);
    run(6, 1, 1);
    chk("skew_last", out, 9'd15);

    // bubble: A toggles, B always valid
    clear_src();
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      src_a.push_back(DW'($urandom));
      src_b.push_back(DW'($urandom));
    end
    run(40, 2, 1);

    // mid-stream reset
    clear_src();
    for (int i = 0; i < 30; i++) begin
      src_a.push_back(DW'(i + 40));
      src_b.push_back(DW'(i + 7));
    end
    run(8, 1, 1);
    cycle(1'b1, 1, 1, 0);
    run(12, 1, 1);

    // operand wrap 255->0
    clear_src();
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      src_a.push_back(DW'(253 + i));
      src_b.push_back(DW'(i + 1));
    end
    run(10, 1, 1);

    // random valids and data
    clear_src();
    for (int i = 0; i < 150; i++) begin
      src_a.push_back(DW'($urandom));
      src_b.push_back(DW'($urandom));
    end
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 59) == 0) cycle(1'b1, 3, 3, k);
      else cycle(1'b0, 3, 3, k);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
